// File: rtl/tracker_pkg.sv
// tracker_pkg: shared FSM states, drive directions and helpers for the sun tracker.
// TRACKER_NIGHT_PARK_EN adds the PARK state.
package tracker_pkg;
    localparam int TIMER_W = 32;
`ifdef TRACKER_NIGHT_PARK_EN
    typedef enum logic [2:0] {IDLE, COMPARE, MOVE_AZ, MOVE_EL, SETTLE, PARK} state_t;
`else
    typedef enum logic [2:0] {IDLE, COMPARE, MOVE_AZ, MOVE_EL, SETTLE} state_t;
`endif
    typedef enum logic [1:0] {DIR_N, DIR_E, DIR_S, DIR_W} dir_t;
    function automatic logic [16:0] abs17(input logic signed [16:0] v);
        return v[16] ? 17'(-v) : 17'(v);
    endfunction
endpackage

// File: rtl/move_timer.sv
// move_timer: loadable 32-bit down-counter; o_done is high on the last counted cycle.
module move_timer
    import tracker_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_val,
    output logic               o_done
);
    logic [TIMER_W-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else if (i_load) r_cnt <= i_val;
        else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
    assign o_done = (r_cnt == TIMER_W'(1));
endmodule

// File: rtl/tracker_control.sv
// tracker_control: two-axis sun tracker FSM driving N/E/S/W motors from four lux sensors.
// Define TRACKER_NIGHT_PARK_EN to park east when the total light falls below NIGHT_LUX.
module tracker_control
    import tracker_pkg::*;
#(
    parameter logic [15:0] DEADBAND      = 16'd200,
    parameter int          MOVE_CYCLES   = 50000,
    parameter int          SETTLE_CYCLES = 100000,
    parameter logic [17:0] NIGHT_LUX     = 18'd50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample,
    input  logic [15:0] n_lux,
    input  logic [15:0] e_lux,
    input  logic [15:0] s_lux,
    input  logic [15:0] w_lux,
    input  logic        limit_n,
    input  logic        limit_e,
    input  logic        limit_s,
    input  logic        limit_w,
    output logic        drv_n,
    output logic        drv_e,
    output logic        drv_s,
    output logic        drv_w,
    output logic        busy,
    output logic        fault
);
    state_t r_state, w_next;
    dir_t r_dir, w_dir;
    logic [15:0] r_n, r_e, r_s, r_w;
    logic r_fault;
    logic w_load, w_done, w_lim, w_fault_now, w_fault, w_drv_on, w_park_e;
    logic [TIMER_W-1:0] w_load_val;
    logic signed [16:0] w_diff_ew, w_diff_ns;
    logic w_az_ok, w_el_ok;

    assign w_fault_now = (limit_e & limit_w) | (limit_n & limit_s);
    assign w_fault = r_fault | w_fault_now;
    assign w_diff_ew = $signed({1'b0, r_e}) - $signed({1'b0, r_w});
    assign w_diff_ns = $signed({1'b0, r_n}) - $signed({1'b0, r_s});
    // Move only toward the brighter side, and only if that side's end-stop is clear.
    assign w_az_ok = (abs17(w_diff_ew) > {1'b0, DEADBAND}) && !(w_diff_ew[16] ? limit_w : limit_e);
    assign w_el_ok = (abs17(w_diff_ns) > {1'b0, DEADBAND}) && !(w_diff_ns[16] ? limit_s : limit_n);
    assign w_lim = (r_dir == DIR_N) ? limit_n : (r_dir == DIR_E) ? limit_e :
                   (r_dir == DIR_S) ? limit_s : limit_w;
`ifdef TRACKER_NIGHT_PARK_EN
    logic [17:0] w_sum;
    assign w_sum = 18'(r_n) + 18'(r_e) + 18'(r_s) + 18'(r_w);
    assign w_park_e = (r_state == PARK) && !limit_e && !w_fault;
`else
    assign w_park_e = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        w_dir = r_dir;
        w_load = 1'b0;
        w_load_val = '0;
        if (w_fault) w_next = IDLE;
        else case (r_state)
            IDLE: if (sample) w_next = COMPARE;
            COMPARE: begin
`ifdef TRACKER_NIGHT_PARK_EN
                if (w_sum < NIGHT_LUX) w_next = PARK;
                else
`endif
                if (w_az_ok) begin
                    w_next = MOVE_AZ;
                    w_dir = w_diff_ew[16] ? DIR_W : DIR_E;
                    w_load = 1'b1;
                    w_load_val = TIMER_W'(MOVE_CYCLES);
                end else if (w_el_ok) begin
                    w_next = MOVE_EL;
                    w_dir = w_diff_ns[16] ? DIR_S : DIR_N;
                    w_load = 1'b1;
                    w_load_val = TIMER_W'(MOVE_CYCLES);
                end else w_next = IDLE;
            end
            MOVE_AZ, MOVE_EL: if (w_lim || w_done) begin
                w_next = SETTLE;
                w_load = 1'b1;
                w_load_val = TIMER_W'(SETTLE_CYCLES);
            end
            SETTLE: if (w_done) w_next = IDLE;
`ifdef TRACKER_NIGHT_PARK_EN
            PARK: if (limit_e) w_next = IDLE;
`endif
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_dir <= DIR_N;
            r_fault <= 1'b0;
            {r_n, r_e, r_s, r_w} <= '0;
        end else begin
            r_state <= w_next;
            r_dir <= w_dir;
            if (w_fault_now) r_fault <= 1'b1;
            if (r_state == IDLE && sample && !w_fault) {r_n, r_e, r_s, r_w} <= {n_lux, e_lux, s_lux, w_lux};
        end
    end

    move_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_val  (w_load_val),
        .o_done (w_done)
    );

    // The limit gates the drive combinationally so it drops in the cycle the switch closes.
    assign w_drv_on = (r_state == MOVE_AZ || r_state == MOVE_EL) && !w_lim && !w_fault;
    assign drv_n = w_drv_on && r_dir == DIR_N;
    assign drv_e = (w_drv_on && r_dir == DIR_E) || w_park_e;
    assign drv_s = w_drv_on && r_dir == DIR_S;
    assign drv_w = w_drv_on && r_dir == DIR_W;
    assign busy = (r_state != IDLE);
    assign fault = r_fault;
endmodule

// File: tb/tb_tracker_control.sv
// tb_tracker_control: directed checks of tracker_control with short move/settle times.
module tb_tracker_control;
    localparam int MC = 5;
    localparam int SC = 4;
    logic clk = 0, rst = 1, sample = 0;
    logic [15:0] n_lux = 0, e_lux = 0, s_lux = 0, w_lux = 0;
    logic limit_n = 0, limit_e = 0, limit_s = 0, limit_w = 0;
    logic drv_n, drv_e, drv_s, drv_w, busy, fault;
    int errors = 0, checks = 0;

    tracker_control #(.MOVE_CYCLES(MC), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .sample(sample),
        .n_lux(n_lux), .e_lux(e_lux), .s_lux(s_lux), .w_lux(w_lux),
        .limit_n(limit_n), .limit_e(limit_e), .limit_s(limit_s), .limit_w(limit_w),
        .drv_n(drv_n), .drv_e(drv_e), .drv_s(drv_s), .drv_w(drv_w),
        .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [15:0] n, input logic [15:0] e, input logic [15:0] s, input logic [15:0] w);
        {n_lux, e_lux, s_lux, w_lux} = {n, e, s, w};
        sample = 1;
        tick();
        sample = 0;
    endtask

    task automatic run_len(input string tag, input int exp);
        int len = 0;
        while (drv_n | drv_e | drv_s | drv_w && len < 100) begin
            len++;
            tick();
        end
        chk(tag, len, exp);
    endtask

    task automatic settle_out(input string tag);
        chk({tag, "_s0"}, busy, 1);
        repeat (SC - 1) tick();
        chk({tag, "_s3"}, busy, 1);
        tick();
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #12;
        chk("rst_out", {drv_n, drv_e, drv_s, drv_w, busy, fault}, 0);
        rst = 0;
        tick();
        go(300, 1000, 300, 500);
        chk("az_c1_busy", busy, 1);
        chk("az_c1_drv", {drv_n, drv_e, drv_s, drv_w}, 0);
        tick();
        chk("az_c2_drv", {drv_n, drv_e, drv_s, drv_w}, 4'b0100);
        run_len("az_len", MC);
        settle_out("az");
        go(300, 700, 300, 500);
        chk("db_c1_busy", busy, 1);
        tick();
        chk("db_busy", busy, 0);
        chk("db_drv", {drv_n, drv_e, drv_s, drv_w}, 0);
        go(300, 701, 300, 500);
        tick();
        chk("db1_drv", {drv_n, drv_e, drv_s, drv_w}, 4'b0100);
        run_len("db1_len", MC);
        settle_out("db1");
        limit_e = 1;
        go(800, 1000, 300, 500);
        tick();
        chk("el_drv", {drv_n, drv_e, drv_s, drv_w}, 4'b1000);
        run_len("el_len", MC);
        settle_out("el");
        limit_e = 0;
        go(300, 100, 300, 2000);
        tick();
        chk("lw_c2", {drv_n, drv_e, drv_s, drv_w}, 4'b0001);
        tick();
        chk("lw_c3", {drv_n, drv_e, drv_s, drv_w}, 4'b0001);
        limit_w = 1;
        #1;
        chk("lw_drop", {drv_n, drv_e, drv_s, drv_w}, 0);
        tick();
        chk("lw_drv_settle", {drv_n, drv_e, drv_s, drv_w}, 0);
        settle_out("lw");
        limit_w = 0;
        go(900, 300, 100, 300);
        tick();
        chk("rs_drv", {drv_n, drv_e, drv_s, drv_w}, 4'b1000);
        tick();
        #2 rst = 1;
        #1;
        chk("rs_drop", {drv_n, drv_e, drv_s, drv_w, busy}, 0);
        chk("rs_cnt", dut.u_timer.r_cnt, 0);
        rst = 0;
        tick();
        chk("rs_idle", {drv_n, drv_e, drv_s, drv_w, busy}, 0);
        go(10, 10, 10, 10);
        tick();
`ifdef TRACKER_NIGHT_PARK_EN
        chk("park_drv", {drv_n, drv_e, drv_s, drv_w}, 4'b0100);
        repeat (MC + 3) tick();
        chk("park_hold", drv_e, 1);
        limit_e = 1;
        #1;
        chk("park_drop", drv_e, 0);
        tick();
        chk("park_idle", busy, 0);
        limit_e = 0;
`else
        chk("night_drv", {drv_n, drv_e, drv_s, drv_w}, 0);
        chk("night_idle", busy, 0);
`endif
        limit_n = 1;
        limit_s = 1;
        #1;
        chk("flt_drv", {drv_n, drv_e, drv_s, drv_w}, 0);
        tick();
        chk("flt_set", fault, 1);
        limit_n = 0;
        limit_s = 0;
        go(300, 1000, 300, 500);
        chk("flt_ign_busy", busy, 0);
        tick();
        chk("flt_ign_drv", {drv_n, drv_e, drv_s, drv_w, busy, fault}, 6'b000001);
        #2 rst = 1;
        #1;
        chk("flt_clr", fault, 0);
        rst = 0;
        tick();
        go(300, 1000, 300, 500);
        tick();
        chk("post_flt_drv", {drv_n, drv_e, drv_s, drv_w}, 4'b0100);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
